// File: rtl/smi_frame_arbiter_xn_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | smi_frame_arbiter_xn_if                                                   |
// | Bundle of the N SMI input streams and the merged SMI output stream.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface smi_frame_arbiter_xn_if #(
   parameter int NumInputs      = 4,
   parameter int InputIndexSize = 2,
   parameter int FlitWidth      = 16
);
   logic [NumInputs-1:0]             inReady;
   logic [NumInputs*8-1:0]           inEofc;
   logic [NumInputs*FlitWidth*8-1:0] inData;
   logic [NumInputs-1:0]             inStop;
   logic                             outReady;
   logic [7:0]                       outEofc;
   logic [FlitWidth*8-1:0]           outData;
   logic                             outStop;
   logic [InputIndexSize-1:0]        outSelect;
   logic                             busy;

   // Upstream sources and downstream sink together.
   modport master (
      output inReady, inEofc, inData, outStop,
      input  inStop, outReady, outEofc, outData, outSelect, busy
   );

   // The arbiter itself.
   modport slave (
      input  inReady, inEofc, inData, outStop,
      output inStop, outReady, outEofc, outData, outSelect, busy
   );
endinterface
`default_nettype wire

// File: rtl/smi_frame_arbiter_xn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | smi_frame_arbiter_xn                                                      |
// | Frame-atomic N-input SMI arbiter, round-robin at frame boundaries, with   |
// | a 2-entry output buffer. SMI_ARB_PRIORITY_EN gives input 0 priority.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module smi_frame_arbiter_xn #(
   parameter int NumInputs      = 4,
   parameter int InputIndexSize = 2,
   parameter int FlitWidth      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   smi_frame_arbiter_xn_if.slave  bus
);
   localparam int DataWidth = FlitWidth * 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_stateNext;
   logic [InputIndexSize-1:0] r_grant;
   logic [InputIndexSize-1:0] r_lastGrant;
   logic [InputIndexSize-1:0] w_pick;
   logic [InputIndexSize-1:0] w_scanIdx;
   logic                      w_found;
   logic                      w_anyReq;

   logic [7:0]                r_bufEofc [2];
   logic [DataWidth-1:0]      r_bufData [2];
   logic                      r_wrPtr;
   logic                      r_rdPtr;
   logic [1:0]                r_count;

   logic                      w_bufFull;
   logic                      w_accept;
   logic                      w_lastFlit;
   logic                      w_pop;
   logic [7:0]                w_selEofc;
   logic [DataWidth-1:0]      w_selData;
   logic [NumInputs-1:0]      w_inStop;

   assign w_anyReq   = |bus.inReady;
   assign w_bufFull  = (r_count == 2'd2);
   assign w_selEofc  = bus.inEofc[8*int'(r_grant) +: 8];
   assign w_selData  = bus.inData[DataWidth*int'(r_grant) +: DataWidth];
   assign w_accept   = (r_state == LOCKED) && bus.inReady[r_grant] && !w_bufFull;
   assign w_lastFlit = w_accept && (w_selEofc != 8'd0);
   assign w_pop      = (r_count != 2'd0) && !bus.outStop;

   // Scan starts one past the previous winner so every requester is reached within N grants.
   always_comb begin
      w_pick    = '0;
      w_found   = 1'b0;
      w_scanIdx = '0;
`ifdef SMI_ARB_PRIORITY_EN
      if (bus.inReady[0]) begin
         w_found = 1'b1;
      end
`endif
      for (int k = 1; k <= NumInputs; k++) begin
         w_scanIdx = InputIndexSize'((int'(r_lastGrant) + k) % NumInputs);
         if (!w_found && bus.inReady[w_scanIdx]) begin
            w_pick  = w_scanIdx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_inStop    = {NumInputs{1'b1}};
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_stateNext = LOCKED;
            end
         end
         LOCKED: begin
            w_inStop[r_grant] = w_bufFull;
            if (w_lastFlit) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant     <= InputIndexSize'(NumInputs - 1);
         r_lastGrant <= InputIndexSize'(NumInputs - 1);
      end else begin
         if ((r_state == IDLE) && w_anyReq) begin
            r_grant <= w_pick;
         end
         if (w_lastFlit) begin
            r_lastGrant <= r_grant;
         end
      end
   end

   // Push is held off by inStop when full, so count never exceeds 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < 2; e++) begin
            r_bufEofc[e] <= 8'd0;
            r_bufData[e] <= '0;
         end
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_accept) begin
            r_bufEofc[r_wrPtr] <= w_selEofc;
            r_bufData[r_wrPtr] <= w_selData;
            r_wrPtr            <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.inStop    = w_inStop;
   assign bus.outReady  = (r_count != 2'd0);
   assign bus.outEofc   = (r_count != 2'd0) ? r_bufEofc[r_rdPtr] : 8'd0;
   assign bus.outData   = (r_count != 2'd0) ? r_bufData[r_rdPtr] : '0;
   assign bus.outSelect = r_grant;
   assign bus.busy      = (r_state == LOCKED) || (r_count != 2'd0);

endmodule
`default_nettype wire
